// File: rtl/l1_miss_queue_if.sv
// rtl/l1_miss_queue_if.sv - signal bundle between L1 tag lookup, l1_miss_queue, L2 and tag memory
//
// Purpose: groups the miss request, L2 fill request/response and tag-update/wake
//          signals of l1_miss_queue so they travel as one port.
// Signals:
//   miss_*            miss request from the tag lookup stage
//   full_o            no free entry
//   miss_retry_o      miss refused, requester reissues
//   l2_req_*          fill request to L2 (valid/ack handshake)
//   l2_resp_*         fill completion from L2
//   update_*          tag memory write (way/tag/set)
//   wake_strands_o    one-hot mask of strands to resume
// Modports: slave (the miss queue), master (the surrounding environment).
`ifndef L1_TAG_WIDTH
`define L1_TAG_WIDTH 21
`endif
`ifndef L1_SET_INDEX_WIDTH
`define L1_SET_INDEX_WIDTH 5
`endif

interface l1_miss_queue_if #(
  parameter int ENTRY_INDEX_WIDTH = 2
);
  logic                           miss_i;
  logic [25:0]                    miss_addr_i;
  logic [1:0]                     miss_way_i;
  logic [1:0]                     miss_strand_i;
  logic                           full_o;
  logic                           miss_retry_o;
  logic                           l2_req_valid_o;
  logic                           l2_req_ack_i;
  logic [25:0]                    l2_req_addr_o;
  logic [ENTRY_INDEX_WIDTH-1:0]   l2_req_id_o;
  logic                           l2_resp_valid_i;
  logic [ENTRY_INDEX_WIDTH-1:0]   l2_resp_id_i;
  logic                           update_o;
  logic [1:0]                     update_way_o;
  logic [`L1_TAG_WIDTH-1:0]       update_tag_o;
  logic [`L1_SET_INDEX_WIDTH-1:0] update_set_o;
  logic [3:0]                     wake_strands_o;

  modport slave (
    input  miss_i, miss_addr_i, miss_way_i, miss_strand_i,
    input  l2_req_ack_i, l2_resp_valid_i, l2_resp_id_i,
    output full_o, miss_retry_o, l2_req_valid_o, l2_req_addr_o, l2_req_id_o,
    output update_o, update_way_o, update_tag_o, update_set_o, wake_strands_o
  );

  modport master (
    output miss_i, miss_addr_i, miss_way_i, miss_strand_i,
    output l2_req_ack_i, l2_resp_valid_i, l2_resp_id_i,
    input  full_o, miss_retry_o, l2_req_valid_o, l2_req_addr_o, l2_req_id_o,
    input  update_o, update_way_o, update_tag_o, update_set_o, wake_strands_o
  );
endinterface

// File: rtl/l1_miss_queue.sv
// rtl/l1_miss_queue.sv - outstanding L1 line-miss tracker: allocates entries, issues L2 fills, updates tags, wakes strands
//
// Purpose: each entry is IDLE, PENDING (awaiting L2 issue) or ISSUED (awaiting L2
//          response) and holds line address, victim way and a waiter mask.
//          A miss to a line already tracked never allocates a second entry.
// Ports:
//   clk     clock
//   reset   asynchronous, active-high; discards every entry
//   bus     l1_miss_queue_if.slave: miss in, L2 request/response, tag update, wake mask
// Optional feature: define L1_MISS_MERGE_EN to merge a matching miss into the
//   existing entry's waiter mask; otherwise the miss is refused with miss_retry_o.
`ifndef L1_TAG_WIDTH
`define L1_TAG_WIDTH 21
`endif
`ifndef L1_SET_INDEX_WIDTH
`define L1_SET_INDEX_WIDTH 5
`endif

module l1_miss_queue #(
  parameter int NUM_ENTRIES       = 4,
  parameter int ENTRY_INDEX_WIDTH = 2
) (
  input logic            clk,
  input logic            reset,
  l1_miss_queue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2
  } entry_state_e;

  localparam int IW = ENTRY_INDEX_WIDTH;

  entry_state_e state_q   [NUM_ENTRIES];
  entry_state_e state_d   [NUM_ENTRIES];
  logic [25:0]  addr_q    [NUM_ENTRIES];
  logic [25:0]  addr_d    [NUM_ENTRIES];
  logic [1:0]   way_q     [NUM_ENTRIES];
  logic [1:0]   way_d     [NUM_ENTRIES];
  logic [3:0]   waiters_q [NUM_ENTRIES];
  logic [3:0]   waiters_d [NUM_ENTRIES];

  // Once an entry is presented to L2 it stays presented until acked, even if a
  // lower-index entry becomes PENDING meanwhile, so the request holds stable.
  logic          req_lock_q, req_lock_d;
  logic [IW-1:0] req_idx_q, req_idx_d;

  logic                           retry_q, retry_d;
  logic                           update_q, update_d;
  logic [1:0]                     update_way_q, update_way_d;
  logic [`L1_TAG_WIDTH-1:0]       update_tag_q, update_tag_d;
  logic [`L1_SET_INDEX_WIDTH-1:0] update_set_q, update_set_d;
  logic [3:0]                     wake_q, wake_d;

  logic          free_found, pend_found, match_found;
  logic [IW-1:0] free_idx, pend_idx, match_idx;
  logic          req_valid, resp_hit, full;
  logic [IW-1:0] req_idx;
  logic [3:0]    strand_oh;

  // Scans run from the top index down so the lowest matching index wins.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    pend_found  = 1'b0;
    pend_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_IDLE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (state_q[i] == ST_PENDING) begin
        pend_found = 1'b1;
        pend_idx   = IW'(i);
      end
      if (state_q[i] != ST_IDLE && addr_q[i] == bus.miss_addr_i) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    full      = !free_found;
    req_valid = req_lock_q || pend_found;
    req_idx   = req_lock_q ? req_idx_q : pend_idx;
    resp_hit  = bus.l2_resp_valid_i && (state_q[bus.l2_resp_id_i] == ST_ISSUED);
    strand_oh = 4'b0001 << bus.miss_strand_i;
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i]   = state_q[i];
      addr_d[i]    = addr_q[i];
      way_d[i]     = way_q[i];
      waiters_d[i] = waiters_q[i];
    end
    req_lock_d   = req_valid && !bus.l2_req_ack_i;
    req_idx_d    = req_idx;
    retry_d      = 1'b0;
    update_d     = 1'b0;
    update_way_d = '0;
    update_tag_d = '0;
    update_set_d = '0;
    wake_d       = '0;

    if (req_valid && bus.l2_req_ack_i) begin
      state_d[req_idx] = ST_ISSUED;
    end

    if (resp_hit) begin
      state_d[bus.l2_resp_id_i] = ST_IDLE;
      update_d     = 1'b1;
      update_way_d = way_q[bus.l2_resp_id_i];
      update_tag_d = addr_q[bus.l2_resp_id_i][25:`L1_SET_INDEX_WIDTH];
      update_set_d = addr_q[bus.l2_resp_id_i][`L1_SET_INDEX_WIDTH-1:0];
      wake_d       = waiters_q[bus.l2_resp_id_i];
    end

    // A miss while full is a protocol violation and is dropped outright. The
    // free index comes from registered state, so an entry freed this cycle is
    // not reused until the next one.
    if (bus.miss_i && !full) begin
      if (match_found) begin
`ifdef L1_MISS_MERGE_EN
        waiters_d[match_idx] = waiters_q[match_idx] | strand_oh;
        // Entry completing this very cycle: the merged strand joins its wake pulse.
        if (resp_hit && bus.l2_resp_id_i == match_idx) begin
          wake_d = wake_d | strand_oh;
        end
`else
        retry_d = 1'b1;
`endif
      end else begin
        state_d[free_idx]   = ST_PENDING;
        addr_d[free_idx]    = bus.miss_addr_i;
        way_d[free_idx]     = bus.miss_way_i;
        waiters_d[free_idx] = strand_oh;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]   <= ST_IDLE;
        addr_q[i]    <= '0;
        way_q[i]     <= '0;
        waiters_q[i] <= '0;
      end
      req_lock_q   <= 1'b0;
      req_idx_q    <= '0;
      retry_q      <= 1'b0;
      update_q     <= 1'b0;
      update_way_q <= '0;
      update_tag_q <= '0;
      update_set_q <= '0;
      wake_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]   <= state_d[i];
        addr_q[i]    <= addr_d[i];
        way_q[i]     <= way_d[i];
        waiters_q[i] <= waiters_d[i];
      end
      req_lock_q   <= req_lock_d;
      req_idx_q    <= req_idx_d;
      retry_q      <= retry_d;
      update_q     <= update_d;
      update_way_q <= update_way_d;
      update_tag_q <= update_tag_d;
      update_set_q <= update_set_d;
      wake_q       <= wake_d;
    end
  end

  assign bus.full_o         = full;
  assign bus.miss_retry_o   = retry_q;
  assign bus.l2_req_valid_o = req_valid;
  assign bus.l2_req_addr_o  = req_valid ? addr_q[req_idx] : '0;
  assign bus.l2_req_id_o    = req_valid ? req_idx : '0;
  assign bus.update_o       = update_q;
  assign bus.update_way_o   = update_way_q;
  assign bus.update_tag_o   = update_tag_q;
  assign bus.update_set_o   = update_set_q;
  assign bus.wake_strands_o = wake_q;

endmodule

// File: doc/l1_miss_queue.md
# l1_miss_queue

Tracks outstanding L1 cache line misses between the L1 tag lookup stage and the L2 request interface. On a tag miss it allocates an entry, issues one L2 fill request per unique line, and on the L2 response drives the tag-memory update port (update/way/tag/set) and wakes every strand waiting on that line. It sits directly downstream of the L1 tag lookup (consumes miss results) and directly upstream of its tag-write port.

## Interface
- NUM_ENTRIES, 4, number of outstanding miss entries (power of two)
- ENTRY_INDEX_WIDTH, 2, log2(NUM_ENTRIES); width of L2 request/response ID

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- miss_i  in  1  lookup missed this cycle; enqueue request
- miss_addr_i  in  26  line address (byte address [31:6])
- miss_way_i  in  2  victim way selected for the fill
- miss_strand_i  in  2  requesting strand ID
- full_o  out  1  no free entry; miss_i must stay low
- miss_retry_o  out  1  miss refused, requester reissues (only without merge)
- l2_req_valid_o  out  1  fill request valid
- l2_req_ack_i  in  1  L2 accepted request this cycle
- l2_req_addr_o  out  26  line address of request
- l2_req_id_o  out  ENTRY_INDEX_WIDTH  entry index
- l2_resp_valid_i  in  1  fill complete
- l2_resp_id_i  in  ENTRY_INDEX_WIDTH  entry being completed
- update_o  out  1  write tag memory (valid=1)
- update_way_o  out  2  way to write
- update_tag_o  out  `L1_TAG_WIDTH  line address [25:5]
- update_set_o  out  `L1_SET_INDEX_WIDTH  line address [4:0]
- wake_strands_o  out  4  one-hot mask of strands to resume

## Operation
- Per-entry state: IDLE, PENDING (awaiting issue), ISSUED (awaiting response). Fields: line address, way, 4-bit waiter mask.
- Enqueue (miss_i, no match): lowest-index IDLE entry -> PENDING, waiter mask = one-hot(miss_strand_i).
- Match: miss_addr_i equals address of any non-IDLE entry -> merge handling (see Configuration); no allocation.
- Issue: lowest-index PENDING entry drives l2_req_*; outputs stable while valid and not acked; on ack entry -> ISSUED.
- Response: entry l2_resp_id_i (must be ISSUED) -> IDLE; registered outputs next cycle: update_o=1 with entry way/tag/set, wake_strands_o=waiter mask.
- full_o = no IDLE entry, computed from registered state only.
- Boundaries: miss_i while full_o is a protocol violation, request dropped; response to non-ISSUED entry ignored; entry freed by response is not reallocatable until next cycle; merge into entry receiving its response in same cycle ORs strand into that cycle's wake mask.

## Timing
- Reset: all entries IDLE; all outputs 0 (full_o=0, l2_req_valid_o=0, update_o=0, wake_strands_o=0).
- Enqueue at edge N -> l2_req_valid_o high in cycle N+1 (earliest).
- Ack in cycle M -> next PENDING entry presented in cycle M+1.
- Response in cycle R -> update_o, wake_strands_o high for exactly cycle R+1; single pulse.
- Response may not arrive in the same cycle as the ack of that ID.
- miss_retry_o is a single-cycle pulse the cycle after the refused miss_i.
- Reset mid-operation: all entries discarded immediately; pending L2 responses after reset are ignored.

## Configuration
- L1_MISS_MERGE_EN defined: matching miss ORs miss_strand_i into the entry's waiter mask; miss_retry_o tied 0.
- Undefined: matching miss is refused, miss_retry_o pulses; waiter mask always single strand.

## Test plan
- Miss addr 0x0001234, way 2, strand 1 -> l2_req addr 0x0001234 id 0 next cycle; ack; response id 0 -> update_o, way 2, tag 0x91, set 0x14, wake 4'b0010.
- Four distinct misses, no ack -> full_o=1 after fourth; requests issued in order ids 0,1,2,3 as acks arrive.
- Same address from strands 0 and 3 with merge -> single L2 request, wake 4'b1001; without merge -> miss_retry_o pulse, wake 4'b0001.
- Responses out of order (id 2 before id 0) -> correct way/tag/set per entry, each pulse one cycle.
- Response freeing entry while full and miss_i arrives same cycle -> miss dropped by protocol; next cycle full_o=0, enqueue succeeds.
- Assert reset with two entries ISSUED -> all outputs 0 next cycle; late response id 1 produces no update_o.
